// File: rtl/datacell_pkg.sv
// Shared defaults and helpers for the datacell buffer and its integrity monitor.
package datacell_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNTW  = 8;

  // Saturating increment of a w-bit value held in a 32-bit container.
  // At all-ones the value is held rather than wrapped.
  // Callers supply widths from 1 to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (v >= max_v) begin
      return max_v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/datacell_satcnt.sv
// CNTW-bit saturating counter with synchronous active-high reset and an increment enable.
module datacell_satcnt
  import datacell_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  output logic [CNTW-1:0] o_cnt
);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_next;

  assign w_cnt_next = CNTW'(sat_inc(32'(r_cnt), CNTW));

  // Count up on each enabled edge, pinning at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/datacell_buffer.sv
// Don't-touch non-inverting buffer cell with a clocked integrity monitor.
// Z is a purely combinational copy of A. The monitor compares Z against A,
// counts input transitions and records which bits have ever been high.
// fi_en flips bit 0 of the compare operand only, so the checker can be
// exercised without ever disturbing the protected net.
module datacell_buffer
  import datacell_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Z,
  input  logic             chk_en,
  input  logic             fi_en,
  output logic             mismatch,
  output logic [CNTW-1:0]  toggle_cnt,
  output logic [WIDTH-1:0] a_seen
);

  // Protected buffer net; kept so synthesis cannot merge or remove it.
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] w_z;
  assign w_z = A;
  assign Z   = w_z;

  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_a_seen;
  logic             r_mismatch;
  logic [WIDTH-1:0] w_fi_mask;
  logic [WIDTH-1:0] w_cmp;
  logic             w_toggle;

  // Fault-injection mask: only bit 0 of the compare operand can be flipped.
  always_comb begin
    w_fi_mask    = '0;
    w_fi_mask[0] = fi_en;
  end

  assign w_cmp    = w_z ^ w_fi_mask;
  assign w_toggle = (A != r_a_q);

  // Input history, sticky bit-seen record and sticky integrity flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_q      <= '0;
      r_a_seen   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_a_q    <= A;
      r_a_seen <= r_a_seen | A;
      if (chk_en && (w_cmp != A)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  datacell_satcnt #(.CNTW(CNTW)) u_satcnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_toggle),
    .o_cnt (toggle_cnt)
  );

  assign mismatch = r_mismatch;
  assign a_seen   = r_a_seen;

endmodule

// File: tb/tb_datacell_buffer.sv
// Directed bench for datacell_buffer: a 1-bit and a 4-bit instance share
// clock, reset and the check/fault controls; each has its own A.
module tb_datacell_buffer;

  logic       clk;
  logic       reset;
  logic       chk_en;
  logic       fi_en;
  logic       a1;
  logic       z1;
  logic       mm1;
  logic [7:0] cnt1;
  logic       seen1;
  logic [3:0] a4;
  logic [3:0] z4;
  logic       mm4;
  logic [7:0] cnt4;
  logic [3:0] seen4;

  int tests;
  int errors;

  logic [7:0] exp_q[$];

  datacell_buffer #(.WIDTH(1), .CNTW(8)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .A          (a1),
    .Z          (z1),
    .chk_en     (chk_en),
    .fi_en      (fi_en),
    .mismatch   (mm1),
    .toggle_cnt (cnt1),
    .a_seen     (seen1)
  );

  datacell_buffer #(.WIDTH(4), .CNTW(8)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .A          (a4),
    .Z          (z4),
    .chk_en     (chk_en),
    .fi_en      (fi_en),
    .mismatch   (mm4),
    .toggle_cnt (cnt4),
    .a_seen     (seen4)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, let one posedge pass, come back to the next negedge.
  task automatic drive(input logic rst, input logic chk, input logic fi,
                       input logic v1, input logic [3:0] v4);
    reset  = rst;
    chk_en = chk;
    fi_en  = fi;
    a1     = v1;
    a4     = v4;
    #1;
    check("z1_follow", 32'(z1), 32'(v1));
    check("z4_follow", 32'(z4), 32'(v4));
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic       chk;
    logic       fi;
    logic       a1;
    logic [3:0] a4;
    logic       mm1;
    logic [7:0] cnt1;
    logic       seen1;
    logic       mm4;
    logic [7:0] cnt4;
    logic [3:0] seen4;
  } vec_t;

  vec_t vecs[13];

  initial begin
    tests  = 0;
    errors = 0;
    reset  = 1'b1;
    chk_en = 1'b0;
    fi_en  = 1'b0;
    a1     = 1'b0;
    a4     = 4'b0000;

    //            rst chk fi a1  a4       mm1 cnt1 seen1 mm4 cnt4 seen4
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 4'b0001};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 8'd1, 1'b1, 1'b0, 8'd2, 4'b0101};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 8'd1, 1'b1, 1'b0, 8'd3, 4'b0101};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd2, 1'b1, 1'b0, 8'd3, 4'b0101};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 8'd2, 1'b1, 1'b1, 8'd3, 4'b0101};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'd2, 1'b1, 1'b1, 8'd3, 4'b0101};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'd2, 1'b1, 1'b1, 8'd3, 4'b0101};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 4'b1111};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 4'b1111};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 4'b1111};

    @(negedge clk);

    // Table-driven section
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].chk, vecs[i].fi, vecs[i].a1, vecs[i].a4);
      check($sformatf("v%0d_mm1", i),   32'(mm1),   32'(vecs[i].mm1));
      check($sformatf("v%0d_cnt1", i),  32'(cnt1),  32'(vecs[i].cnt1));
      check($sformatf("v%0d_seen1", i), 32'(seen1), 32'(vecs[i].seen1));
      check($sformatf("v%0d_mm4", i),   32'(mm4),   32'(vecs[i].mm4));
      check($sformatf("v%0d_cnt4", i),  32'(cnt4),  32'(vecs[i].cnt4));
      check($sformatf("v%0d_seen4", i), 32'(seen4), 32'(vecs[i].seen4));
    end

    // Z tracks A asynchronously between edges, including under reset
    reset = 1'b1;
    fi_en = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #2; a1 = 1'b0; a4 = 4'b1010; #1;
    check("async_z1_0", 32'(z1), 32'd0);
    check("async_z4_a", 32'(z4), 32'h0000_000a);
    #1; a1 = 1'b1; a4 = 4'b0101; #0;
    check("async_z1_1", 32'(z1), 32'd1);
    check("async_z4_5", 32'(z4), 32'h0000_0005);
    @(negedge clk);
    #1; a1 = 1'b0; a4 = 4'b0000; #1;
    check("async_z1_2", 32'(z1), 32'd0);
    check("async_z4_0", 32'(z4), 32'd0);
    check("rst_mm1", 32'(mm1), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);

    // Saturation: toggle A every cycle for 300 cycles
    fi_en  = 1'b0;
    chk_en = 1'b0;
    reset  = 1'b0;
    begin
      logic [7:0] model;
      model = 8'd0;
      for (int c = 0; c < 300; c++) begin
        a1 = ~a1;
        a4 = {4{a1}};
        model = (model == 8'hFF) ? 8'hFF : model + 8'd1;
        exp_q.push_back(model);
        @(posedge clk);
        @(negedge clk);
        begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check($sformatf("sat1_c%0d", c), 32'(cnt1), 32'(e));
          if (c == 299) check("sat4_end", 32'(cnt4), 32'(e));
        end
      end
    end

    // Held input: saturated count must not move
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold1_c%0d", c), 32'(cnt1), 32'd255);
      check($sformatf("hold4_c%0d", c), 32'(cnt4), 32'd255);
    end

    // Mid-operation reset together with a fault: reset wins
    drive(1'b1, 1'b1, 1'b1, a1, a4);
    check("midrst_mm1", 32'(mm1), 32'd0);
    check("midrst_cnt1", 32'(cnt1), 32'd0);
    check("midrst_mm4", 32'(mm4), 32'd0);
    check("midrst_cnt4", 32'(cnt4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/datacell_buffer.md
Name: datacell_buffer

Overview:
- Don't-touch, non-inverting buffer cell for security-critical single-net or bus control signals, such as the latched ATPG-mode flag driven out of chip mode selection.
- Z follows A combinationally with zero cycle latency; synthesis must preserve the cell so the net cannot be optimized away or merged.
- A clocked integrity monitor sits beside the data path. It checks Z against A, counts input transitions and records which bits have ever been high, so tamper or glitch activity is visible to system control.

Parameters:
- WIDTH, 1, bit width of A and Z.
- CNTW, 8, width of the saturating transition counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  buffer input.
- Z  output  WIDTH  buffer output; combinational copy of A.
- chk_en  input  1  enables the Z-versus-A integrity compare.
- fi_en  input  1  fault injection; inverts bit 0 of the compare operand only, never Z.
- mismatch  output  1  sticky integrity error.
- toggle_cnt  output  CNTW  saturating count of clock edges at which A changed.
- a_seen  output  WIDTH  sticky per-bit OR of sampled A.

Behaviour:
- Z = A at all times, purely combinational.
  - Z is independent of clk, reset, chk_en and fi_en.
  - Z keeps following A while reset is asserted.
- All monitor registers clear to 0 on any rising clk edge with reset = 1: a_q, mismatch, toggle_cnt, a_seen.
- a_q: register that samples A every clk edge when reset = 0.
- Transition counter:
  - At each edge with reset = 0 and A != a_q, toggle_cnt increments by 1.
  - toggle_cnt saturates at all-ones and never wraps.
  - a_q is 0 after reset, so A != 0 at the first post-reset edge counts as one transition.
- a_seen: at each edge with reset = 0, a_seen <= a_seen | A.
- Integrity compare:
  - Compare operand cmp = Z with bit 0 XORed by fi_en.
  - At each edge with reset = 0 and chk_en = 1, if cmp != A then mismatch <= 1.
  - mismatch is sticky and cleared only by reset.
  - Latency: mismatch rises one clk edge after the offending cycle.
  - With chk_en = 0, mismatch holds its value.
- Simultaneous reset and fault: reset wins; mismatch = 0 after that edge.
- No handshakes and no FSM. All monitor outputs are registered; only Z is combinational.

Decomposition:
- Package datacell_pkg holds:
  - WIDTH and CNTW defaults;
  - the saturating-increment helper function.
- One sub-module, datacell_satcnt: a parameterized CNTW-bit saturating counter with synchronous active-high reset and an increment-enable input.
- The buffer path instance must carry a don't-touch/keep attribute.

Test Plan:
- Z tracking:
  - Stimulus: WIDTH = 1; drive A = 0, 1, 0 asynchronously between clock edges, including while reset = 1.
  - Required: Z equals A within the same delta at every point; no clock dependence.
- Reset clearing:
  - Stimulus: reset = 1 for 2 edges with A = 1.
  - Required: mismatch = 0, toggle_cnt = 0, a_seen = 0, Z = 1.
  - Stimulus: release reset.
  - Required: after the first edge, toggle_cnt = 1 and a_seen = 1.
- Counter saturation:
  - Stimulus: CNTW = 8; toggle A every cycle for 300 cycles.
  - Required: toggle_cnt climbs to 255 and stays at 255; it never returns to 0.
  - Stimulus: A held constant.
  - Required: toggle_cnt does not change.
- Fault injection:
  - Stimulus: chk_en = 1, fi_en = 1 for one cycle.
  - Required: mismatch = 1 after that edge and stays 1 after fi_en = 0.
  - Stimulus: repeat with chk_en = 0.
  - Required: mismatch stays 0.
- Reset priority and mid-operation reset:
  - Stimulus: assert reset on the same edge as fi_en = 1 and chk_en = 1.
  - Required: mismatch = 0 and toggle_cnt = 0.
  - Required: Z still equals A throughout.
- Multi-bit a_seen:
  - Stimulus: WIDTH = 4; pulse A = 4'b0001, then 4'b0100, then 4'b0000.
  - Required: a_seen = 4'b0101; toggle_cnt = 3.
